pc_unit: RTL and testbench

//  Parametrised program-counter unit for the fetch stage: holds the PC and selects the next PC.

---
 rtl/pc_unit.sv | 158 +++++++++++++++
 tb/tb_pc_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the fetch stage.
//
// Holds the PC and picks the next one from: sequential (pc+STEP),
// call/branch target, return address popped from a circular
// return-address stack (RAS), or the exception vector. A stall
// freezes every piece of state for that update.
//
// Optional feature macro: PC_CLK_DIV_EN
//   undefined : pc_tick is tied high and the PC updates every clock.
//   defined   : a DIV_LOG2-bit free-running counter gates updates so they
//               happen once per 2^DIV_LOG2 clocks (single clock domain).
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   stall          in   hold PC, RAS and sticky flags this update
//   exc            in   exception redirect (highest priority)
//   ret            in   return: pop RAS
//   call           in   jump to branch_target and push pc+STEP
//   branch_taken   in   jump to branch_target
//   branch_target  in   redirect target, low ALIGN bits ignored
//   pc             out  current PC (registered)
//   pc_tick        out  high in cycles where an update is permitted
//   ras_empty      out  RAS holds no entries
//   ras_full       out  RAS holds RAS_DEPTH entries
//   ras_overflow   out  sticky: call while full
//   ras_underflow  out  sticky: ret while empty

module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'('h80),
    parameter int               RAS_DEPTH = 4,
    parameter int               DIV_LOG2  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             exc,
    input  logic             ret,
    input  logic             call,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc,
    output logic             pc_tick,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int PTRW = $clog2(RAS_DEPTH);

    // Reject configurations the circular stack and alignment mask rely on.
    if (STEP < 1 || (STEP & (STEP - 1)) != 0 || RAS_DEPTH < 2 ||
        (RAS_DEPTH & (RAS_DEPTH - 1)) != 0 || DIV_LOG2 < 1) begin : g_param_check
        $error("pc_unit: STEP and RAS_DEPTH must be powers of two, RAS_DEPTH >= 2, DIV_LOG2 >= 1");
    end

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTRW-1:0]  ptr;
    logic [PTRW:0]    count;

    logic [WIDTH-1:0] pc_next;
    logic [PTRW-1:0]  ptr_next;
    logic [PTRW:0]    count_next;
    logic             overflow_next;
    logic             underflow_next;
    logic             push;
    logic             update;
    logic [PTRW-1:0]  top_idx;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] target_aligned;

`ifdef PC_CLK_DIV_EN
    logic [DIV_LOG2-1:0] div_cnt;

    // Free-running divider; it keeps counting through stalls so the tick
    // cadence never drifts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_cnt <= '0;
        else        div_cnt <= div_cnt + 1'b1;
    end

    assign pc_tick = &div_cnt;
`else
    assign pc_tick = 1'b1;
`endif

    assign ras_empty = (count == '0);
    assign ras_full  = (count == (PTRW + 1)'(RAS_DEPTH));

    // ptr is the next slot to write, so the newest entry sits just below it.
    // When the stack is full, ptr has wrapped onto the oldest entry, which
    // is exactly the one a further push must overwrite.
    assign top_idx        = ptr - 1'b1;
    assign seq_pc         = pc + WIDTH'(STEP);
    assign target_aligned = branch_target & ~WIDTH'(STEP - 1);
    assign update         = reset & pc_tick & ~stall;

    // Next-state selection in priority order: exc, ret, call, branch, sequential.
    always_comb begin
        pc_next        = pc;
        ptr_next       = ptr;
        count_next     = count;
        overflow_next  = ras_overflow;
        underflow_next = ras_underflow;
        push           = 1'b0;
        if (update) begin
            if (exc) begin
                pc_next    = EXC_VEC;
                count_next = '0;
            end else if (ret) begin
                if (!ras_empty) begin
                    pc_next    = ras_mem[top_idx];
                    ptr_next   = top_idx;
                    count_next = count - 1'b1;
                end else begin
                    pc_next        = seq_pc;
                    underflow_next = 1'b1;
                end
            end else if (call) begin
                pc_next  = target_aligned;
                push     = 1'b1;
                ptr_next = ptr + 1'b1;
                if (ras_full) overflow_next = 1'b1;
                else          count_next    = count + 1'b1;
            end else if (branch_taken) begin
                pc_next = target_aligned;
            end else begin
                pc_next = seq_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc            <= RESET_VEC;
            ptr           <= '0;
            count         <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_next;
            ptr           <= ptr_next;
            count         <= count_next;
            ras_overflow  <= overflow_next;
            ras_underflow <= underflow_next;
        end
    end

    // Entry contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clk) begin
        if (push) ras_mem[ptr] <= seq_pc;
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit in its default build
// (WIDTH=32, STEP=4, RAS_DEPTH=4, divider disabled).
//
// A behavioural model keeps the PC as a plain number and the return stack
// as a queue (push_back on call, pop_back on ret, pop_front when a fifth
// entry arrives). Directed sequences pin the model to hand-computed values,
// then randomized traffic with occasional mid-cycle resets follows.

module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, exc, ret, call, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic        pc_tick, ras_empty, ras_full, ras_overflow, ras_underflow;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] modelPc;
    logic [31:0] modelRas[$];
    logic        modelOvf;
    logic        modelUnf;

    pc_unit #(
        .WIDTH    (32),
        .STEP     (4),
        .RESET_VEC(32'h0),
        .EXC_VEC  (32'h80),
        .RAS_DEPTH(4),
        .DIV_LOG2 (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .exc          (exc),
        .ret          (ret),
        .call         (call),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .pc           (pc),
        .pc_tick      (pc_tick),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    // Single comparison point: every check funnels through here.
    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the behavioural model.
    task automatic checkOutput();
        checkValue("pc", pc, modelPc);
        checkValue("pc_tick", 32'(pc_tick), 32'd1);
        checkValue("ras_empty", 32'(ras_empty), 32'(modelRas.size() == 0));
        checkValue("ras_full", 32'(ras_full), 32'(modelRas.size() == 4));
        checkValue("ras_overflow", 32'(ras_overflow), 32'(modelOvf));
        checkValue("ras_underflow", 32'(ras_underflow), 32'(modelUnf));
    endtask

    task automatic modelReset();
        modelPc = 32'h0;
        modelRas.delete();
        modelOvf = 1'b0;
        modelUnf = 1'b0;
    endtask

    // One update of the architectural rules, applied to the model.
    task automatic modelStep(input logic s, input logic e, input logic r,
                             input logic c, input logic b, input logic [31:0] t);
        if (s) return;
        if (e) begin
            modelPc = 32'h80;
            modelRas.delete();
        end else if (r) begin
            if (modelRas.size() > 0) begin
                modelPc = modelRas.pop_back();
            end else begin
                modelPc = modelPc + 32'd4;
                modelUnf = 1'b1;
            end
        end else if (c) begin
            if (modelRas.size() == 4) begin
                void'(modelRas.pop_front());
                modelOvf = 1'b1;
            end
            modelRas.push_back(modelPc + 32'd4);
            modelPc = {t[31:2], 2'b00};
        end else if (b) begin
            modelPc = {t[31:2], 2'b00};
        end else begin
            modelPc = modelPc + 32'd4;
        end
    endtask

    // Drive one cycle of inputs, let the DUT take the edge, advance the model
    // and compare.
    task automatic applyStimulus(input logic s, input logic e, input logic r,
                                 input logic c, input logic b, input logic [31:0] t);
        stall = s; exc = e; ret = r; call = c; branch_taken = b; branch_target = t;
        @(posedge clk);
        #1;
        modelStep(s, e, r, c, b, t);
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Assert reset away from any clock edge, confirm it takes effect at once,
    // then release it mid-cycle.
    task automatic doReset();
        #3;
        reset = 1'b0;
        #1;
        modelReset();
        checkValue("async_reset_pc", pc, 32'h0);
        checkOutput();
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0; exc = 1'b0; ret = 1'b0; call = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        modelReset();
        #2;
        checkValue("reset_pc", pc, 32'h0);
        checkValue("reset_empty", 32'(ras_empty), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;

        // Reset release followed by sequential fetch.
        idle();
        idle();
        checkValue("seq_pc8", pc, 32'h8);
        // Stall holds the PC, then a misaligned branch target is aligned.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkValue("stall_hold", pc, 32'h8);
        idle();
        checkValue("seq_pcC", pc, 32'hC);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h103);
        checkValue("branch_align", pc, 32'h100);

        // Call and matching return.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200);
        checkValue("call_pc", pc, 32'h200);
        checkValue("call_not_empty", 32'(ras_empty), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkValue("ret_pc", pc, 32'h14);
        checkValue("ret_empty", 32'(ras_empty), 32'd1);

        // Five calls overflow the four-entry stack; the oldest return is lost.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300 + 32'(i) * 32'h100);
        checkValue("ovf_flag", 32'(ras_overflow), 32'd1);
        checkValue("ovf_full", 32'(ras_full), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkValue("ret_newest", pc, 32'h604);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkValue("ret_fourth", pc, 32'h304);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkValue("unf_pc", pc, 32'h308);
        checkValue("unf_flag", 32'(ras_underflow), 32'd1);

        // Priorities and wrap-around.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h800);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h900);
        checkValue("exc_pc", pc, 32'h80);
        checkValue("exc_flush", 32'(ras_empty), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h900);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA00);
        checkValue("retcall_pc", pc, 32'h84);
        checkValue("retcall_empty", 32'(ras_empty), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        checkValue("top_pc", pc, 32'hFFFF_FFFC);
        idle();
        checkValue("wrap_pc", pc, 32'h0);

        // Randomized traffic with occasional mid-cycle resets.
        for (int seg = 0; seg < 4; seg++) begin
            doReset();
            for (int i = 0; i < 500; i++) begin
                applyStimulus($urandom_range(7) == 0,
                              $urandom_range(15) == 0,
                              $urandom_range(3) == 0,
                              $urandom_range(2) == 0,
                              $urandom_range(3) == 0,
                              (seg == 3) ? 32'hFFFF_FF00 | $urandom_range(255) : $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
